// File: rtl/stack_op_controller_if.sv
// Stack-op request, stack-pointer and data-memory signals of the MEM-stage stack controller.
// The pipeline/environment side uses master; the controller uses slave.
interface stack_op_controller_if;
    logic       op_valid;
    logic [2:0] op_code;
    logic [7:0] push_data;
    logic [7:0] pc_in;
    logic [3:0] flags_in;
    logic [7:0] sp_value;
    logic       sp_update_en;
    logic [7:0] sp_new;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic       fault;
    logic [7:0] pop_data;
    logic [7:0] ret_pc;
    logic [3:0] ret_flags;

    modport master (
        output op_valid, op_code, push_data, pc_in, flags_in, sp_value, mem_rdata,
        input  sp_update_en, sp_new, mem_addr, mem_wdata, mem_we, mem_re,
        input  busy, done, fault, pop_data, ret_pc, ret_flags
    );

    modport slave (
        input  op_valid, op_code, push_data, pc_in, flags_in, sp_value, mem_rdata,
        output sp_update_en, sp_new, mem_addr, mem_wdata, mem_we, mem_re,
        output busy, done, fault, pop_data, ret_pc, ret_flags
    );
endinterface

// File: rtl/stack_op_controller.sv
// Sequences stack-pointer updates and data-memory accesses for PUSH/POP/CALL/RET/INTR/RTI.
// Stack grows down from STACK_TOP; sp_value addresses the next free slot.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for op_valid; latches operands on accept
//  W1      | first write (PUSH data / return PC), SP-1
//  W2      | INTR second write (zero-extended flags), SP-1
//  R1      | first read at SP+1, SP+1
//  R1W     | capture first read word
//  R2      | RTI second read at SP+1, SP+1
//  R2W     | capture RTI return PC
//  DONE    | done pulse
//  FAULT   | done + fault pulse (overflow, underflow, illegal op)
module stack_op_controller #(
    parameter logic [7:0] STACK_TOP   = 8'hFF,
    parameter logic [7:0] STACK_LIMIT = 8'h80
) (
    input  logic               clk,
    input  logic               reset,
    stack_op_controller_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_W1, S_W2, S_R1, S_R1W, S_R2, S_R2W, S_DONE, S_FAULT
    } state_t;

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_CALL = 3'b010;
    localparam logic [2:0] OP_RET  = 3'b011;
    localparam logic [2:0] OP_INTR = 3'b100;
    localparam logic [2:0] OP_RTI  = 3'b101;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] data_q, data_d;
    logic [7:0] pc_q, pc_d;
    logic [3:0] flags_q, flags_d;
    logic [7:0] pop_data_q, pop_data_d;
    logic [7:0] ret_pc_q, ret_pc_d;
    logic [3:0] ret_flags_q, ret_flags_d;

    logic       mem_we, mem_re, sp_update_en, done, fault, busy;
    logic [7:0] mem_addr, mem_wdata, sp_new;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        data_d       = data_q;
        pc_d         = pc_q;
        flags_d      = flags_q;
        pop_data_d   = pop_data_q;
        ret_pc_d     = ret_pc_q;
        ret_flags_d  = ret_flags_q;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        sp_update_en = 1'b0;
        mem_addr     = 8'h00;
        mem_wdata    = 8'h00;
        sp_new       = 8'h00;
        done         = 1'b0;
        fault        = 1'b0;
        busy         = 1'b0;

        // Reset blanks every strobe so an aborted op cannot touch memory on the reset edge.
        if (!reset) begin
            busy = (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        op_d    = bus.op_code;
                        data_d  = bus.push_data;
                        pc_d    = bus.pc_in;
                        flags_d = bus.flags_in;
                        case (bus.op_code)
                            OP_PUSH, OP_CALL, OP_INTR: state_d = S_W1;
                            OP_POP, OP_RET, OP_RTI:    state_d = S_R1;
                            default:                   state_d = S_FAULT;
                        endcase
                    end
                end
                S_W1, S_W2: begin
                    if (bus.sp_value < STACK_LIMIT) begin
                        state_d = S_FAULT;
                    end else begin
                        mem_we       = 1'b1;
                        mem_addr     = bus.sp_value;
                        sp_update_en = 1'b1;
                        sp_new       = bus.sp_value - 8'd1;
                        if (state_q == S_W2) begin
                            mem_wdata = {4'b0000, flags_q};
                            state_d   = S_DONE;
                        end else begin
                            mem_wdata = (op_q == OP_PUSH) ? data_q : pc_q;
                            state_d   = (op_q == OP_INTR) ? S_W2 : S_DONE;
                        end
                    end
                end
                S_R1, S_R2: begin
                    if (bus.sp_value == STACK_TOP) begin
                        state_d = S_FAULT;
                    end else begin
                        mem_re       = 1'b1;
                        mem_addr     = bus.sp_value + 8'd1;
                        sp_update_en = 1'b1;
                        sp_new       = bus.sp_value + 8'd1;
                        state_d      = (state_q == S_R1) ? S_R1W : S_R2W;
                    end
                end
                S_R1W: begin
                    case (op_q)
                        OP_POP:  pop_data_d  = bus.mem_rdata;
                        OP_RET:  ret_pc_d    = bus.mem_rdata;
                        OP_RTI:  ret_flags_d = bus.mem_rdata[3:0];
                        default: ;
                    endcase
                    state_d = (op_q == OP_RTI) ? S_R2 : S_DONE;
                end
                S_R2W: begin
                    ret_pc_d = bus.mem_rdata;
                    state_d  = S_DONE;
                end
                S_DONE: begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
                S_FAULT: begin
                    done    = 1'b1;
                    fault   = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 3'b000;
            data_q      <= 8'h00;
            pc_q        <= 8'h00;
            flags_q     <= 4'h0;
            pop_data_q  <= 8'h00;
            ret_pc_q    <= 8'h00;
            ret_flags_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            pc_q        <= pc_d;
            flags_q     <= flags_d;
            pop_data_q  <= pop_data_d;
            ret_pc_q    <= ret_pc_d;
            ret_flags_q <= ret_flags_d;
        end
    end

    assign bus.mem_we       = mem_we;
    assign bus.mem_re       = mem_re;
    assign bus.sp_update_en = sp_update_en;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.sp_new       = sp_new;
    assign bus.done         = done;
    assign bus.fault        = fault;
    assign bus.busy         = busy;
    assign bus.pop_data     = pop_data_q;
    assign bus.ret_pc       = ret_pc_q;
    assign bus.ret_flags    = ret_flags_q;
endmodule

// File: tb/tb_stack_op_controller.sv
// Scoreboard bench for stack_op_controller: directed ops queue expected writes, reads and
// completions; a negedge monitor pops and compares whenever the DUT strobes them.
module tb_stack_op_controller;
    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_CALL = 3'b010;
    localparam logic [2:0] OP_RET  = 3'b011;
    localparam logic [2:0] OP_INTR = 3'b100;
    localparam logic [2:0] OP_RTI  = 3'b101;

    typedef struct {
        logic       fault;
        logic [7:0] pop;
        logic [7:0] rpc;
        logic [3:0] rfl;
        logic [7:0] sp;
        int         lat;
    } done_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stack_op_controller_if bus();
    stack_op_controller dut (.clk(clk), .reset(reset), .bus(bus));

    // Environment: stack_pointer register and data memory with one-cycle read latency.
    logic [7:0] sp_m;
    logic [7:0] rdata_m;
    logic [7:0] mem [256];
    assign bus.sp_value  = sp_m;
    assign bus.mem_rdata = rdata_m;

    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) sp_m <= 8'hFF;
        else if (bus.sp_update_en) sp_m <= bus.sp_new;
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (reset) rdata_m <= 8'h00;
        else if (bus.mem_re) rdata_m <= mem[bus.mem_addr];
    end

    done_t      dq[$];
    wr_t        wq[$];
    logic [7:0] rq[$];
    int checks = 0;
    int passes = 0;
    int done_cnt = 0;
    int accept_cyc = 0;

    logic [7:0] exp_sp, exp_pop, exp_rpc;
    logic [3:0] exp_rfl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic exp_done(input logic f, input int lat);
        done_t e;
        e.fault = f;
        e.pop   = exp_pop;
        e.rpc   = exp_rpc;
        e.rfl   = exp_rfl;
        e.sp    = exp_sp;
        e.lat   = lat;
        dq.push_back(e);
    endtask

    // Monitor: temporaries live at module scope so nothing is shared with the stimulus.
    wr_t        m_w;
    done_t      m_d;
    logic [7:0] m_a;
    logic [7:0] m_e8;
    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (wq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                m_w  = wq.pop_front();
                m_e8 = m_w.addr - 8'd1;
                chk("wr_addr", {24'h0, bus.mem_addr}, {24'h0, m_w.addr});
                chk("wr_data", {24'h0, bus.mem_wdata}, {24'h0, m_w.data});
                chk("wr_sp_update_en", {31'h0, bus.sp_update_en}, 32'd1);
                chk("wr_sp_new", {24'h0, bus.sp_new}, {24'h0, m_e8});
            end
        end
        if (bus.mem_re) begin
            if (rq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_read: addr %0h, expected no read", bus.mem_addr);
            end else begin
                m_a = rq.pop_front();
                chk("rd_addr", {24'h0, bus.mem_addr}, {24'h0, m_a});
                chk("rd_sp_update_en", {31'h0, bus.sp_update_en}, 32'd1);
                chk("rd_sp_new", {24'h0, bus.sp_new}, {24'h0, m_a});
            end
        end
        if (bus.fault && !bus.done) begin
            checks++;
            $display("FAIL fault_without_done: fault 1 done 0, expected done with fault");
        end
        if (bus.done) begin
            done_cnt++;
            if (dq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: fault %0b, expected no completion", bus.fault);
            end else begin
                m_d = dq.pop_front();
                chk("done_fault", {31'h0, bus.fault}, {31'h0, m_d.fault});
                chk("done_latency", cyc - accept_cyc, m_d.lat);
                chk("done_sp", {24'h0, sp_m}, {24'h0, m_d.sp});
                chk("pop_data", {24'h0, bus.pop_data}, {24'h0, m_d.pop});
                chk("ret_pc", {24'h0, bus.ret_pc}, {24'h0, m_d.rpc});
                chk("ret_flags", {28'h0, bus.ret_flags}, {28'h0, m_d.rfl});
            end
        end
    end

    // Issues one op and waits for its completion; poke keeps op_valid high with a POP
    // for two busy cycles, which must be ignored.
    task automatic issue(input logic [2:0] op, input logic [7:0] d, input logic [7:0] pc,
                         input logic [3:0] fl, input bit poke);
        int n;
        int start;
        n = 0;
        @(posedge clk); #1;
        while (bus.busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) begin
            checks++;
            $display("FAIL busy_timeout: busy still 1 after 50 cycles, expected 0");
        end
        bus.op_code   = op;
        bus.push_data = d;
        bus.pc_in     = pc;
        bus.flags_in  = fl;
        bus.op_valid  = 1'b1;
        accept_cyc    = cyc;
        start         = done_cnt;
        @(posedge clk); #1;
        if (poke) begin
            bus.op_code = OP_POP;
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        bus.op_valid = 1'b0;
        n = 0;
        while (done_cnt == start && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt == start) begin
            checks++;
            $display("FAIL done_timeout: op %0d no done within 30 cycles, expected done", op);
        end
    endtask

    logic [7:0] old_fe;
    logic [7:0] pd;

    initial begin
        bus.op_valid  = 1'b0;
        bus.op_code   = 3'b000;
        bus.push_data = 8'h00;
        bus.pc_in     = 8'h00;
        bus.flags_in  = 4'h0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        exp_sp = 8'hFF; exp_pop = 8'h00; exp_rpc = 8'h00; exp_rfl = 4'h0;

        chk("rst_busy", {31'h0, bus.busy}, 32'd0);
        chk("rst_done", {31'h0, bus.done}, 32'd0);
        chk("rst_strobes", {29'h0, bus.mem_we, bus.mem_re, bus.sp_update_en}, 32'd0);
        chk("rst_held", {12'h0, bus.pop_data, bus.ret_pc, bus.ret_flags}, 32'd0);

        exp_wr(8'hFF, 8'h3C); exp_sp = 8'hFE; exp_done(1'b0, 2);
        issue(OP_PUSH, 8'h3C, 8'h00, 4'h0, 1'b0);

        rq.push_back(8'hFF); exp_sp = 8'hFF; exp_pop = 8'h3C; exp_done(1'b0, 3);
        issue(OP_POP, 8'h00, 8'h00, 4'h0, 1'b0);

        exp_wr(8'hFF, 8'h42); exp_wr(8'hFE, 8'h05); exp_sp = 8'hFD; exp_done(1'b0, 3);
        issue(OP_INTR, 8'h00, 8'h42, 4'h5, 1'b0);

        rq.push_back(8'hFE); rq.push_back(8'hFF);
        exp_sp = 8'hFF; exp_rfl = 4'h5; exp_rpc = 8'h42; exp_done(1'b0, 5);
        issue(OP_RTI, 8'h00, 8'h00, 4'h0, 1'b0);

        exp_wr(8'hFF, 8'h77); exp_sp = 8'hFE; exp_done(1'b0, 2);
        issue(OP_CALL, 8'h00, 8'h77, 4'h0, 1'b0);

        rq.push_back(8'hFF); exp_sp = 8'hFF; exp_rpc = 8'h77; exp_done(1'b0, 3);
        issue(OP_RET, 8'h00, 8'h00, 4'h0, 1'b0);

        exp_done(1'b1, 2);
        issue(OP_POP, 8'h00, 8'h00, 4'h0, 1'b0);

        exp_done(1'b1, 1);
        issue(3'b110, 8'h00, 8'h00, 4'h0, 1'b0);
        exp_done(1'b1, 1);
        issue(3'b111, 8'h00, 8'h00, 4'h0, 1'b0);

        exp_wr(8'hFF, 8'h5A); exp_sp = 8'hFE; exp_done(1'b0, 2);
        issue(OP_PUSH, 8'h5A, 8'h00, 4'h0, 1'b1);
        repeat (3) @(posedge clk);
        #1 chk("ignored_while_busy", {31'h0, bus.busy}, 32'd0);

        for (int i = 0; i < 200 && exp_sp >= 8'h80; i++) begin
            pd = exp_sp ^ 8'h55;
            exp_wr(exp_sp, pd);
            exp_sp = exp_sp - 8'd1;
            exp_done(1'b0, 2);
            issue(OP_PUSH, pd, 8'h00, 4'h0, 1'b0);
        end
        chk("fill_sp", {24'h0, sp_m}, 32'h7F);

        exp_done(1'b1, 2);
        issue(OP_PUSH, 8'hEE, 8'h00, 4'h0, 1'b0);

        rq.push_back(8'h80); exp_sp = 8'h80; exp_pop = 8'hD5; exp_done(1'b0, 3);
        issue(OP_POP, 8'h00, 8'h00, 4'h0, 1'b0);

        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_sp = 8'hFF; exp_pop = 8'h00; exp_rpc = 8'h00; exp_rfl = 4'h0;
        chk("rst2_held", {12'h0, bus.pop_data, bus.ret_pc, bus.ret_flags}, 32'd0);

        exp_wr(8'hFF, 8'h9A);
        bus.op_code  = OP_INTR;
        bus.pc_in    = 8'h9A;
        bus.flags_in = 4'h3;
        bus.op_valid = 1'b1;
        @(posedge clk); #1 bus.op_valid = 1'b0;
        @(posedge clk); #1;
        old_fe = mem[8'hFE];
        chk("w2_busy", {31'h0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("abort_busy", {31'h0, bus.busy}, 32'd0);
        chk("abort_strobes", {29'h0, bus.mem_we, bus.mem_re, bus.sp_update_en}, 32'd0);
        chk("abort_no_w2_write", {24'h0, mem[8'hFE]}, {24'h0, old_fe});
        chk("abort_w1_write", {24'h0, mem[8'hFF]}, 32'h9A);
        chk("abort_held", {12'h0, bus.pop_data, bus.ret_pc, bus.ret_flags}, 32'd0);
        repeat (4) @(posedge clk);

        #1;
        chk("wq_empty", wq.size(), 32'd0);
        chk("rq_empty", rq.size(), 32'd0);
        chk("dq_empty", dq.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
